alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Multi-cycle ALU stage feeding the accumulator (AC). Receives an op code and a start strobe from the
//   control unit, takes operand A from AC dataout and operand B from the shared bus, and returns an
//   N-bit result on alu_out with a one-cycle alu_to_ac write strobe. ADD/SUB/logic/shift ops take one
//   cycle. MUL is an iterative shift-add that takes N cycles. busy stalls the control unit meanwhile.
// PARAMETERS
//   N      12   datapath width (bus, AC, operands, result); legal range 4..32
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   start      in   1      op request; sampled only when busy==0
//   alu_op     in   3      0 ADD, 1 SUB (A-B), 2 MUL, 3 PASSB, 4 AND, 5 SHL1(A), 6 SHR1(A), 7 illegal
//   a_in       in   N      operand A (AC dataout)
//   b_in       in   N      operand B (bus)
//   alu_out    out  N      registered result, held until next completion
//   alu_to_ac  out  1      one-cycle pulse: alu_out valid, AC must load it
//   busy       out  1      high while a MUL is in progress
//   ovf        out  1      overflow/carry of last completed op (registered with alu_out)
//   z_flag     out  1      1 when last completed alu_out == 0
// BEHAVIOUR
//   Reset: all outputs 0, FSM in IDLE, iteration counter 0. This is a clk-independent async clear.
//   FSM states: IDLE, MUL.
//   IDLE, start=1, op!=MUL (edge k):
//     - compute from live a_in/b_in, then load alu_out/ovf/z_flag.
//     - alu_to_ac=1 for the single cycle after edge k. Stay in IDLE. Latency 1.
//   IDLE, start=1, op==MUL (edge k):
//     - latch multiplicand=a_in, multiplier=b_in, product=0, cnt=0.
//     - busy<=1, go to MUL.
//   MUL: each edge, if multiplier LSB then product+=multiplicand<<cnt (2N-bit acc). Then cnt++.
//     - At the edge where cnt reaches N (edge k+N): alu_out<=product[N-1:0],
//       ovf<=|product[2N-1:N], busy<=0, alu_to_ac pulses one cycle, return to IDLE.
//   Arithmetic: ADD ovf=carry out of bit N-1. SUB ovf=borrow (A<B unsigned). SHL1 ovf=A[N-1].
//     - SHR1 ovf=A[0], logical shift. AND/PASSB ovf=0. All results truncated to N bits, unsigned.
//   Illegal op 7: alu_out<=0, ovf<=0, z_flag<=1, alu_to_ac pulses (control never hangs).
//   start while busy=1: ignored, no queuing, operands not resampled.
//   start in the alu_to_ac cycle (busy already 0): accepted; back-to-back ops allowed.
//   alu_to_ac is never high for two consecutive cycles from one op; 0 whenever start was not accepted.
//   Reset mid-MUL: operation aborted, no alu_to_ac pulse, outputs cleared per reset.
//   start=0 in IDLE: all outputs hold (alu_to_ac=0).
// TESTING  (N=12)
//   ADD a=0xFFF b=0x001 -> next cycle alu_out=0x000, ovf=1, z_flag=1, alu_to_ac one cycle.
//   SUB a=0x005 b=0x007 -> alu_out=0xFFE, ovf=1, z_flag=0. Back-to-back ADD 3+4 next cycle -> 0x007.
//   MUL a=25 b=40 -> busy for 12 cycles, then alu_out=0x3E8, ovf=0, single alu_to_ac pulse at edge k+12.
//   MUL a=0x100 b=0x010 -> alu_out=0x000, ovf=1, z_flag=1. Start ADD pulses during busy -> ignored.
//   Mid-MUL rst_n=0 at cycle 5 -> outputs 0 immediately (async), no pulse. Next MUL 3*3 -> 0x009.
//   SHL1 a=0x801 -> 0x002, ovf=1. SHR1 a=0x001 -> 0x000, ovf=1, z=1. op=7 -> 0x000, pulse, ovf=0.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU stage for the accumulator path: single-cycle ADD/SUB/logic/shift ops
// and an N-cycle iterative shift-add MUL, with a registered result and a one-cycle AC load strobe.
module alu_seq #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   alu_op,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] alu_out,
  output logic         alu_to_ac,
  output logic         busy,
  output logic         ovf,
  output logic         z_flag
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_PASSB = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_SHL1  = 3'd5;
  localparam logic [2:0] OP_SHR1  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state_r;
  logic [N-1:0]     mcand_r;
  logic [N-1:0]     mlier_r;
  logic [2*N-1:0]   prod_r;
  logic [CW-1:0]    cnt_r;

  logic [N:0]       res_s;        // bit N carries the op's ovf flag
  logic [2*N-1:0]   addend_s;
  logic [2*N-1:0]   prod_next_s;

  // Single-cycle result and flag; SUB's bit N is the unsigned borrow (A < B).
  always_comb begin
    res_s = {(N+1){1'b0}};
    case (alu_op)
      OP_ADD:   res_s = {1'b0, a_in} + {1'b0, b_in};
      OP_SUB:   res_s = {1'b0, a_in} - {1'b0, b_in};
      OP_PASSB: res_s = {1'b0, b_in};
      OP_AND:   res_s = {1'b0, a_in & b_in};
      OP_SHL1:  res_s = {a_in[N-1], a_in[N-2:0], 1'b0};
      OP_SHR1:  res_s = {a_in[0], 1'b0, a_in[N-1:1]};
      default:  res_s = {(N+1){1'b0}};
    endcase
  end

  // One shift-add step of the multiplier, consuming the multiplier LSB.
  always_comb begin
    addend_s    = {(2*N){1'b0}};
    if (mlier_r[0]) begin
      addend_s = {{N{1'b0}}, mcand_r} << cnt_r;
    end else begin
      addend_s = {(2*N){1'b0}};
    end
    prod_next_s = prod_r + addend_s;
  end

  // Control FSM with registered result, flags and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mcand_r   <= '0;
      mlier_r   <= '0;
      prod_r    <= '0;
      cnt_r     <= '0;
      alu_out   <= '0;
      alu_to_ac <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      alu_to_ac <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (alu_op == OP_MUL) begin
              mcand_r <= a_in;
              mlier_r <= b_in;
              prod_r  <= '0;
              cnt_r   <= '0;
              busy    <= 1'b1;
              state_r <= ST_MUL;
            end else begin
              alu_out   <= res_s[N-1:0];
              ovf       <= res_s[N];
              z_flag    <= (res_s[N-1:0] == {N{1'b0}});
              alu_to_ac <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          prod_r  <= prod_next_s;
          mlier_r <= {1'b0, mlier_r[N-1:1]};
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            alu_out   <= prod_next_s[N-1:0];
            ovf       <= |prod_next_s[2*N-1:N];
            z_flag    <= (prod_next_s[N-1:0] == {N{1'b0}});
            alu_to_ac <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
